guess_fifo: RTL and testbench



---
 rtl/hangman_pkg.sv | 11 +
 rtl/letter_filter.sv | 22 ++
 rtl/guess_fifo.sv | 95 +++++++++
 tb/tb_guess_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants for the hangman datapath: ASCII letter bounds and the
// offset that folds lower case onto upper case.
package hangman_pkg;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/letter_filter.sv
// Combinational letter filter: passes upper case letters, folds lower case
// letters to upper case, and flags everything else as not accepted.
module letter_filter
  import hangman_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       accept
);

  always_comb begin
    out    = in;
    accept = 1'b0;
    if (in >= ASCII_A && in <= ASCII_Z) begin
      accept = 1'b1;
    end else if (in >= ASCII_LA && in <= ASCII_LZ) begin
      accept = 1'b1;
      out    = in - CASE_OFS;
    end
  end

endmodule

// File: rtl/guess_fifo.sv
// Receive-side guess buffer: optional letter filter in front of a
// first-word-fall-through FIFO popped by the game FSM.
module guess_fifo
  import hangman_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [DATA_W-1:0]          Rx_byte,
  input  logic                       game_rdy,
  input  logic                       clr,
  output logic [DATA_W-1:0]          guess,
  output logic                       guess_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       reject
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] filt_byte;
  logic              accept;
  logic              push;
  logic              pop;

  generate
    if (FILTER_EN) begin : g_filter
      letter_filter u_filter (
        .in     (Rx_byte),
        .out    (filt_byte),
        .accept (accept)
      );
    end else begin : g_bypass
      assign filt_byte = Rx_byte;
      assign accept    = 1'b1;
    end
  endgenerate

  assign guess_valid = (count != '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign guess       = guess_valid ? mem[rd_ptr] : '0;

  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign pop  = game_rdy && guess_valid;
  assign push = ready && accept && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !clr && !rst) begin
      mem[wr_ptr] <= filt_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      reject   <= 1'b0;
    end else begin
      reject <= ready && !accept;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
        if (ready && accept && full && !pop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_guess_fifo.sv
// Directed bench for guess_fifo with a queue scoreboard of expected guesses;
// a second instance checks the unfiltered pass-through build.
module tb_guess_fifo;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       game_rdy = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] guess;
  logic       guess_valid;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       reject;

  logic       ready_b = 1'b0;
  logic [7:0] rx_byte_b = 8'h00;
  logic [7:0] guess_b;
  logic       guess_valid_b;
  logic       full_b;
  logic [2:0] count_b;
  logic       overflow_b;
  logic       reject_b;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q [$];
  logic       exp_ovf = 1'b0;
  logic       exp_rej = 1'b0;

  always #5 tb_clk = ~tb_clk;

  guess_fifo #(.DATA_W(8), .DEPTH(4), .FILTER_EN(1'b1)) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .ready       (ready),
    .Rx_byte     (rx_byte),
    .game_rdy    (game_rdy),
    .clr         (clr),
    .guess       (guess),
    .guess_valid (guess_valid),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .reject      (reject)
  );

  guess_fifo #(.DATA_W(8), .DEPTH(4), .FILTER_EN(1'b0)) dut_raw (
    .clk         (tb_clk),
    .rst         (rst),
    .ready       (ready_b),
    .Rx_byte     (rx_byte_b),
    .game_rdy    (1'b0),
    .clr         (1'b0),
    .guess       (guess_b),
    .guess_valid (guess_valid_b),
    .full        (full_b),
    .count       (count_b),
    .overflow    (overflow_b),
    .reject      (reject_b)
  );

  // Reference filter: bit 8 is accept, low byte is the folded letter.
  function automatic logic [8:0] model_filter(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return {1'b1, b};
    if (b >= 8'h61 && b <= 8'h7A) return {1'b1, b - 8'h20};
    return {1'b0, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState();
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    checkOutput("count", 32'(count), 32'(exp_q.size()));
    checkOutput("guess", 32'(guess), 32'(head));
    checkOutput("guess_valid", 32'(guess_valid), 32'(exp_q.size() > 0));
    checkOutput("full", 32'(full), 32'(exp_q.size() == 4));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("reject", 32'(reject), 32'(exp_rej));
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs.
  task automatic applyStimulus(input logic rdy, input logic [7:0] b,
                               input logic pop_req, input logic flush);
    logic [8:0] f;
    logic       pop_m;
    logic       push_m;
    f       = model_filter(b);
    pop_m   = pop_req && (exp_q.size() > 0);
    push_m  = rdy && f[8] && (exp_q.size() < 4 || pop_m);
    ready    = rdy;
    rx_byte  = b;
    game_rdy = pop_req;
    clr      = flush;
    if (pop_m && !flush) begin
      checkOutput("pop_head", 32'(guess), 32'(exp_q[0]));
    end
    @(posedge tb_clk);
    #1;
    exp_rej = rdy && !f[8];
    if (flush) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (rdy && f[8] && exp_q.size() == 4 && !pop_m) exp_ovf = 1'b1;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(f[7:0]);
    end
    ready    = 1'b0;
    rx_byte  = 8'h00;
    game_rdy = 1'b0;
    clr      = 1'b0;
    checkState();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    rst = 1'b0;
    checkState();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    checkOutput("fold_a", 32'(guess), 32'h41);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h35, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    ready_b   = 1'b1;
    rx_byte_b = 8'h35;
    @(posedge tb_clk);
    #1;
    ready_b   = 1'b0;
    rx_byte_b = 8'h00;
    checkOutput("raw_guess", 32'(guess_b), 32'h35);
    checkOutput("raw_count", 32'(count_b), 32'd1);
    checkOutput("raw_reject", 32'(reject_b), 32'd0);

    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h45, 1'b0, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h45, 1'b1, 1'b0);
    checkOutput("full_rw_count", 32'(count), 32'd4);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h46, 1'b0, 1'b1);

    applyStimulus(1'b1, 8'h47, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h48, 1'b0, 1'b0);
    rst     = 1'b1;
    ready   = 1'b1;
    rx_byte = 8'h49;
    @(posedge tb_clk);
    #1;
    rst     = 1'b0;
    ready   = 1'b0;
    rx_byte = 8'h00;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_rej = 1'b0;
    checkState();
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
